// File: rtl/sync_fifo_pkg.sv
// Shared constants and elaboration helpers for the single-clock FIFO.
package sync_fifo_pkg;

  localparam int unsigned DefDsize    = 8;
  localparam int unsigned DefAsize    = 4;
  localparam int unsigned DefAeThresh = 2;
  localparam bit          DefFwft     = 1'b0;

  function automatic int unsigned depth_of(input int unsigned asize);
    return 32'd1 << asize;
  endfunction

  function automatic int unsigned def_af_thresh(input int unsigned asize);
    return depth_of(asize) - 32'd2;
  endfunction

  function automatic bit af_thresh_ok(input int unsigned af, input int unsigned depth);
    return (af >= 32'd1) && (af <= depth);
  endfunction

  function automatic bit ae_thresh_ok(input int unsigned ae, input int unsigned depth);
    return ae < depth;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake and status bundle for sync_fifo.
interface sync_fifo_if
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DefDsize,
  parameter int unsigned ASIZE = DefAsize
) ();

  logic             clr;
  logic             winc;
  logic [DSIZE-1:0] wdata;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [ASIZE:0]   count;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, winc, wdata, rinc,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  clr, winc, wdata, rinc,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE = DefDsize,
  parameter int unsigned ASIZE = DefAsize
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ASIZE-1:0] waddr,
  input  logic [DSIZE-1:0] wdata,
  input  logic [ASIZE-1:0] raddr,
  output logic [DSIZE-1:0] rdata
);

  localparam int unsigned Depth = depth_of(ASIZE);

  logic [DSIZE-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, threshold flags, flush, sticky errors
// and an optional first-word-fall-through read port.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DSIZE     = DefDsize,
  parameter int unsigned ASIZE     = DefAsize,
  parameter int unsigned AF_THRESH = def_af_thresh(ASIZE),
  parameter int unsigned AE_THRESH = DefAeThresh,
  parameter bit          FWFT      = DefFwft
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_if.slave     bus
);

  localparam int unsigned Depth = depth_of(ASIZE);
  localparam int unsigned CntW  = ASIZE + 1;

  localparam logic [CntW-1:0]  DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0]  AfCnt    = CntW'(AF_THRESH);
  localparam logic [CntW-1:0]  AeCnt    = CntW'(AE_THRESH);
  localparam logic [ASIZE-1:0] PtrOne   = ASIZE'(1);

  if (!af_thresh_ok(AF_THRESH, Depth)) begin : g_bad_af
    $error("sync_fifo: AF_THRESH must lie in 1..DEPTH");
  end
  if (!ae_thresh_ok(AE_THRESH, Depth)) begin : g_bad_ae
    $error("sync_fifo: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [ASIZE-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             afull_q, afull_d, aempty_q, aempty_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             wr_acc, rd_acc, mem_we;
  logic [DSIZE-1:0] mem_rdata;

  always_comb begin
    wr_acc   = bus.winc & ~full_q;
    rd_acc   = bus.rinc & ~empty_q;
    mem_we   = wr_acc & ~bus.clr;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (bus.clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (wr_acc) wptr_d = wptr_q + PtrOne;
      if (rd_acc) rptr_d = rptr_q + PtrOne;
      count_d = count_q + CntW'(wr_acc) - CntW'(rd_acc);
      ovf_d   = ovf_q | (bus.winc & full_q);
      unf_d   = unf_q | (bus.rinc & empty_q);
    end
    // Flags are registered from the next count so they move on the same edge as count.
    full_d   = (count_d == DepthCnt);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AfCnt);
    aempty_d = (count_d <= AeCnt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  sync_fifo_mem #(
    .DSIZE (DSIZE),
    .ASIZE (ASIZE)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wptr_q),
    .wdata (bus.wdata),
    .raddr (rptr_q),
    .rdata (mem_rdata)
  );

  if (FWFT) begin : g_fwft
    // Head word is presented directly; rinc only pops it.
    assign bus.rdata = mem_rdata;
  end else begin : g_std
    logic [DSIZE-1:0] rdata_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata_q <= '0;
      end else if (rd_acc && !bus.clr) begin
        rdata_q <= mem_rdata;
      end
    end
    assign bus.rdata = rdata_q;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: standard-mode instance plus an FWFT instance.
module tb_sync_fifo;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sync_fifo_if #(.DSIZE(8), .ASIZE(4)) f0 ();
  sync_fifo_if #(.DSIZE(8), .ASIZE(4)) f1 ();

  sync_fifo #(
    .DSIZE(8), .ASIZE(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b0)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (f0)
  );

  sync_fifo #(
    .DSIZE(8), .ASIZE(4), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1'b1)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f1)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model of the standard-mode instance.
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;
  bit         m_unf = 1'b0;
  logic [7:0] m_rdata = 8'h00;
  logic [7:0] exp_q [$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string w);
    check_val({w, " count"},        32'(f0.count),        32'(m_cnt));
    check_val({w, " full"},         32'(f0.full),         32'(m_cnt == 16));
    check_val({w, " empty"},        32'(f0.empty),        32'(m_cnt == 0));
    check_val({w, " almost_full"},  32'(f0.almost_full),  32'(m_cnt >= 14));
    check_val({w, " almost_empty"}, 32'(f0.almost_empty), 32'(m_cnt <= 2));
    check_val({w, " overflow"},     32'(f0.overflow),     32'(m_ovf));
    check_val({w, " underflow"},    32'(f0.underflow),    32'(m_unf));
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    exp_q.delete();
  endtask

  // One clock of stimulus on the standard instance; called at #1 after a rising edge.
  task automatic cycle(input bit w, input logic [7:0] d, input bit r, input string tag);
    bit         wacc, racc;
    logic [7:0] e;
    e         = 8'h00;
    f0.winc   = w;
    f0.wdata  = d;
    f0.rinc   = r;
    wacc      = w && (m_cnt != 16);
    racc      = r && (m_cnt != 0);
    if (w && m_cnt == 16) m_ovf = 1'b1;
    if (r && m_cnt == 0)  m_unf = 1'b1;
    if (wacc) exp_q.push_back(d);
    if (racc) e = exp_q.pop_front();
    @(posedge clk);
    #1;
    f0.winc = 1'b0;
    f0.rinc = 1'b0;
    m_cnt   = m_cnt + int'(wacc) - int'(racc);
    if (racc) begin
      m_rdata = e;
      check_val({tag, " rdata"}, 32'(f0.rdata), 32'(e));
    end
    check_flags(tag);
  endtask

  // Flush with winc/rinc also asserted: clr must win and rdata must hold.
  task automatic do_clr(input string tag);
    f0.clr  = 1'b1;
    f0.winc = 1'b1;
    f0.rinc = 1'b1;
    @(posedge clk);
    #1;
    f0.clr  = 1'b0;
    f0.winc = 1'b0;
    f0.rinc = 1'b0;
    model_reset();
    check_flags(tag);
    check_val({tag, " rdata_hold"}, 32'(f0.rdata), 32'(m_rdata));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] fq [$];
    logic [7:0] fe;
    f0.clr = 1'b0; f0.winc = 1'b0; f0.rinc = 1'b0; f0.wdata = 8'h00;
    f1.clr = 1'b0; f1.winc = 1'b0; f1.rinc = 1'b0; f1.wdata = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    check_flags("reset");
    check_val("reset rdata", 32'(f0.rdata), 32'h0);
    check_val("reset fwft empty", 32'(f1.empty), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1, "drain");

    cycle(1'b0, 8'h00, 1'b1, "underflow");
    cycle(1'b1, 8'h42, 1'b1, "empty_wr_rd");
    do_clr("clr1");

    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0, "fill2");
    cycle(1'b1, 8'hEE, 1'b0, "overflow");
    cycle(1'b0, 8'h00, 1'b0, "overflow_sticky");
    cycle(1'b1, 8'h77, 1'b1, "full_wr_rd");
    do_clr("clr2");

    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h50 + i), 1'b0, "pre5");
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1, "simul5");
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, "post5");

    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(i * 7 + 3), 1'b0, "wrap_w");
      cycle(1'b0, 8'h00, 1'b1, "wrap_r");
    end

    // FWFT instance: word is visible the cycle after it is written.
    f1.winc = 1'b1; f1.wdata = 8'hA5;
    @(posedge clk); #1;
    f1.winc = 1'b0;
    check_val("fwft rdata", 32'(f1.rdata), 32'hA5);
    check_val("fwft empty_after_wr", 32'(f1.empty), 32'd0);
    f1.rinc = 1'b1;
    @(posedge clk); #1;
    f1.rinc = 1'b0;
    check_val("fwft empty_after_pop", 32'(f1.empty), 32'd1);
    for (int i = 0; i < 3; i++) begin
      f1.winc = 1'b1; f1.wdata = 8'(8'hB1 + i);
      fq.push_back(8'(8'hB1 + i));
      @(posedge clk); #1;
    end
    f1.winc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fe = fq.pop_front();
      check_val("fwft head", 32'(f1.rdata), 32'(fe));
      f1.rinc = 1'b1;
      @(posedge clk); #1;
      f1.rinc = 1'b0;
    end
    check_val("fwft count_end", 32'(f1.count), 32'd0);

    // Asynchronous reset between edges at count 7.
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0, "pre_rst");
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    m_rdata = 8'h00;
    check_flags("async_rst");
    check_val("async_rst rdata", 32'(f0.rdata), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0, "post_rst_w");
    cycle(1'b0, 8'h00, 1'b1, "post_rst_r");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Parametrised single-clock FIFO, the successor to our dual-clock FIFO for paths where producer and consumer share one clock. It adds occupancy count, programmable almost-full/almost-empty thresholds, a first-word-fall-through (FWFT) mode, a synchronous flush and sticky overflow/underflow error flags. It sits between a producer and a consumer in the same clock domain, with no pointer synchronisers.

## Interface
- DSIZE, 8: data word width in bits.
- ASIZE, 4: address width; DEPTH = 1<<ASIZE entries.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard read (data one cycle after rinc); 1 = head word presented while !empty.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous flush.
- winc  in  1  write request.
- wdata  in  DSIZE  write data.
- rinc  in  1  read request.
- rdata  out  DSIZE  read data.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- count  out  ASIZE+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: winc while full.
- underflow  out  1  sticky: rinc while empty.

## Operation
- Reset values: count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0, rdata=0, both pointers 0. Memory contents are not reset.
- Write acceptance: a write is accepted iff winc && !full. Accepted data goes to mem[wptr] and wptr increments modulo DEPTH.
- Read acceptance: a read is accepted iff rinc && !empty. rptr increments modulo DEPTH.
- Count update: count_next = count + wr_acc - rd_acc.
  - A simultaneous accepted read and write leaves count unchanged.
  - When full, a write is rejected even if a read occurs in the same cycle.
  - When empty, a read is rejected even if a write occurs in the same cycle.
- Flag update: all four status flags are registered and derived from count_next, so they change on the same edge as count.
- overflow sets on winc && full. underflow sets on rinc && empty. Both hold until clr or rst.
- clr takes priority over winc/rinc in the same cycle. It returns pointers, count, flags and sticky bits to their reset values. rdata holds its value in standard mode.
- Standard mode (FWFT=0):
  - rdata is registered and loads mem[rptr] on an accepted read.
  - It holds its value otherwise, including on rejected reads.
- FWFT mode (FWFT=1):
  - rdata = mem[rptr] combinationally whenever !empty.
  - rinc acts as acknowledge/pop.
  - rdata is don't-care while empty.
- Pointers wrap naturally at DEPTH. count, not pointer comparison, is the source of full/empty.

## Timing
- Write at edge N makes count=1 and empty=0 visible after edge N.
- FWFT=1: the word written at edge N is visible on rdata after edge N (one-cycle write-to-read latency).
- FWFT=0: rinc sampled at edge M makes rdata valid after edge M, so minimum write-to-data is 2 cycles.
- full asserts after the edge that accepts the DEPTH-th write. It deasserts after the edge that accepts a read.
- Throughput: one write and one read per cycle, sustained.
- Asserting rst mid-operation forces the reset values immediately, without waiting for a clock edge.

## Structure
- Shared package sync_fifo_pkg holds:
  - the DEPTH derivation;
  - threshold legality checks (elaboration-time errors for AF_THRESH/AE_THRESH out of range);
  - default parameter constants.
- Sub-module sync_fifo_mem: DEPTH x DSIZE register array with one synchronous write port and one asynchronous read port. The top level decides between registered (FWFT=0) and direct (FWFT=1) output.
- The top level contains the pointers, count, flag logic and sticky error bits.

## Test plan
- Fill/drain, DSIZE=8, ASIZE=4: write 0x00..0x0F.
  - Expect full=1 and count=16 after the 16th edge, with almost_full first at count 14.
  - Read 16 words: data 0x00..0x0F in order, empty=1 at end, no overflow/underflow.
- Overflow/underflow:
  - winc when full: count stays 16, overflow=1 and remains set.
  - rinc when empty: underflow=1.
  - clr clears both flags and count.
- Simultaneous read/write:
  - At count=5: count stays 5 and data order is preserved.
  - At full with winc+rinc: read accepted, write rejected, count=15, overflow=1.
  - At empty with winc+rinc: write accepted, count=1, underflow=1.
- Wrap-around: 40 cycles of single writes interleaved with reads (pointers wrap twice). Expect every word matched in order.
- FWFT=1: write 0xA5 at edge N, expect rdata=0xA5 and empty=0 after edge N. With rinc at N+1, expect empty=1 after N+1.
- Reset mid-operation:
  - Assert rst between edges at count=7. Expect count=0, empty=1, flags at reset values immediately.
  - After release, the first write is read back correctly.
